// File: rtl/demux_8bus_1_4.sv
`default_nettype none
// ============================================================================
// Module  : demux_8bus_1_4
// Brief   : Registered 1:4 valid/ready stream demux with a 2-entry FIFO per
//           output channel and a saturating input-stall counter.
// Rev     : 1.0
// ============================================================================
module demux_8bus_1_4 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [3:0]           out_valid,
    input  logic [3:0]           out_ready,
    output logic [4*WIDTH-1:0]   out_data,
    output logic [7:0]           ovf_count
);

    logic [3:0] w_full;
    logic [7:0] r_ovf;

    // Ready depends only on the selected channel's registered fill level,
    // so a full channel never passes a beat through on a same-cycle pop.
    assign in_ready  = ~w_full[in_sel];
    assign ovf_count = r_ovf;

    generate
        for (genvar k = 0; k < 4; k++) begin : g_ch
            localparam logic [1:0] c_ch = 2'(k);

            logic [WIDTH-1:0] r_mem [2];
            logic             r_wr_ptr;
            logic             r_rd_ptr;
            logic [1:0]       r_cnt;
            logic             w_push;
            logic             w_pop;

            assign w_push = in_valid & in_ready & (in_sel == c_ch);
            assign w_pop  = out_valid[k] & out_ready[k];

            assign w_full[k]                   = (r_cnt == 2'd2);
            assign out_valid[k]                = (r_cnt != 2'd0);
            assign out_data[k*WIDTH +: WIDTH]  = r_mem[r_rd_ptr];

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_mem[0] <= '0;
                    r_mem[1] <= '0;
                    r_wr_ptr <= 1'b0;
                    r_rd_ptr <= 1'b0;
                    r_cnt    <= 2'd0;
                end else begin
                    if (w_push) begin
                        r_mem[r_wr_ptr] <= in_data;
                        r_wr_ptr        <= ~r_wr_ptr;
                    end
                    if (w_pop) begin
                        r_rd_ptr <= ~r_rd_ptr;
                    end
                    case ({w_push, w_pop})
                        2'b10:   r_cnt <= r_cnt + 2'd1;
                        2'b01:   r_cnt <= r_cnt - 2'd1;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ovf <= 8'd0;
        end else if (in_valid && !in_ready && (r_ovf != 8'hFF)) begin
            r_ovf <= r_ovf + 8'd1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_8bus_1_4.sv
`default_nettype none
// ============================================================================
// Module  : tb_demux_8bus_1_4
// Brief   : Scoreboard bench for demux_8bus_1_4: per-channel expected queues,
//           directed scenarios plus randomized traffic.
// Rev     : 1.0
// ============================================================================
module tb_demux_8bus_1_4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [7:0]  ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q [4][$];
    int         exp_ovf = 0;

    demux_8bus_1_4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ovf_count (ovf_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a FIFO of capacity 2 holding accepted
    // beats; the input is ready iff the addressed FIFO holds fewer than 2.
    always @(negedge clk) begin
        logic       exp_rdy;
        logic [3:0] exp_vld;
        if (reset) begin
            for (int k = 0; k < 4; k++) exp_q[k].delete();
            exp_ovf = 0;
        end else begin
            exp_rdy = (exp_q[in_sel].size() < 2);
            for (int k = 0; k < 4; k++) exp_vld[k] = (exp_q[k].size() != 0);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("out_valid", 32'(out_valid), 32'(exp_vld));
            chk("ovf_count", 32'(ovf_count), 32'(exp_ovf));
            for (int k = 0; k < 4; k++) begin
                if (exp_vld[k] && out_ready[k]) begin
                    chk($sformatf("out_data[%0d]", k), 32'(out_data[k*8 +: 8]), 32'(exp_q[k][0]));
                    void'(exp_q[k].pop_front());
                end
            end
            if (in_valid && exp_rdy) exp_q[in_sel].push_back(in_data);
            else if (in_valid && exp_ovf < 255) exp_ovf++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [1:0] s, input logic [7:0] d);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: ch %0d data 0x%0h never accepted", s, d);
        in_valid = 1'b0;
    endtask

    task automatic send_hold(input logic [1:0] s, input logic [7:0] d, input int n);
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        idle(n);
        in_valid = 1'b0;
    endtask

    initial begin
        logic rdy;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        out_ready = 4'b0000;
        @(posedge clk);
        #1;
        idle(2);
        reset = 1'b0;

        // Idle after reset: ready for every destination
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            idle(1);
        end

        // Basic routing
        out_ready = 4'b1111;
        for (int s = 0; s < 4; s++) send(2'(s), 8'(s + 1));
        idle(3);

        // Full channel, backpressure, in-order drain
        out_ready = 4'b0000;
        send(2'd2, 8'hA1);
        send(2'd2, 8'hA2);
        fork
            send(2'd2, 8'hA3);
            begin
                idle(5);
                out_ready[2] = 1'b1;
            end
        join
        idle(4);

        // Isolation: full channel 0 does not block channel 3
        out_ready = 4'b0000;
        send(2'd0, 8'h31);
        send(2'd0, 8'h32);
        send(2'd3, 8'h55);
        idle(2);
        out_ready = 4'b1111;
        idle(3);

        // Streaming into channel 1
        out_ready = 4'b0010;
        for (int i = 0; i < 16; i++) send(2'd1, 8'(8'h10 + i));
        idle(3);

        // Randomized traffic honouring the producer hold rule
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            if (!in_valid || rdy) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_sel   = 2'($urandom_range(0, 3));
                in_data  = 8'($urandom_range(0, 255));
            end
            out_ready = 4'($urandom_range(0, 15));
        end
        in_valid = 1'b0;
        out_ready = 4'b1111;
        idle(4);

        // Mid-operation reset, then stall-counter saturation
        out_ready = 4'b0000;
        send(2'd0, 8'hC0);
        send(2'd1, 8'hC1);
        send(2'd0, 8'hC2);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(1);
        send(2'd0, 8'hD0);
        send(2'd0, 8'hD1);
        in_valid = 1'b1;
        in_sel   = 2'd0;
        in_data  = 8'hD2;
        idle(300);
        @(negedge clk);
        chk("ovf_saturated", 32'(ovf_count), 32'h0000_00FF);
        tick();
        in_valid  = 1'b0;
        out_ready = 4'b1111;
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
